// File: rtl/vedic_mac_pkg.sv
// Shared types and constants for the vedic_mac streaming MAC stage.
// Imported by the multiplier wrapper and the top.
package vedic_mac_pkg;

   localparam int ACC_W_DEF = 40;
   localparam int CNT_W_DEF = 16;
   localparam int OP_W      = 16;
   localparam int PROD_W    = 32;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      HOLD  = 2'd2
   } state_t;

   // Signed add overflow: equal addend signs, different sum sign.
   function automatic logic add_ovf(
      input logic i_sa,
      input logic i_sb,
      input logic i_ss
   );
      return (i_sa == i_sb) && (i_ss != i_sa);
   endfunction

endpackage

// File: rtl/vedic_mac_vedic1.sv
// vedic1: combinational 16x16 signed multiplier built from a
// recursive Urdhva-Tiryagbhyam tree over operand magnitudes.
module vedic1
   import vedic_mac_pkg::*;
(
   input  logic [OP_W-1:0]   i_a,
   input  logic [OP_W-1:0]   i_b,
   output logic [PROD_W-1:0] o_p
);

   function automatic logic [3:0] vm2(
      input logic [1:0] a,
      input logic [1:0] b
   );
      logic c;
      c = (a[1] & b[0]) & (a[0] & b[1]);
      return {(a[1] & b[1]) & c,
              (a[1] & b[1]) ^ c,
              (a[1] & b[0]) ^ (a[0] & b[1]),
              a[0] & b[0]};
   endfunction

   function automatic logic [7:0] vm4(
      input logic [3:0] a,
      input logic [3:0] b
   );
      logic [3:0] ll, lh, hl, hh;
      ll = vm2(a[1:0], b[1:0]);
      lh = vm2(a[1:0], b[3:2]);
      hl = vm2(a[3:2], b[1:0]);
      hh = vm2(a[3:2], b[3:2]);
      return {4'b0, ll} + {2'b0, lh, 2'b0}
           + {2'b0, hl, 2'b0} + {hh, 4'b0};
   endfunction

   function automatic logic [15:0] vm8(
      input logic [7:0] a,
      input logic [7:0] b
   );
      logic [7:0] ll, lh, hl, hh;
      ll = vm4(a[3:0], b[3:0]);
      lh = vm4(a[3:0], b[7:4]);
      hl = vm4(a[7:4], b[3:0]);
      hh = vm4(a[7:4], b[7:4]);
      return {8'b0, ll} + {4'b0, lh, 4'b0}
           + {4'b0, hl, 4'b0} + {hh, 8'b0};
   endfunction

   function automatic logic [31:0] vm16(
      input logic [15:0] a,
      input logic [15:0] b
   );
      logic [15:0] ll, lh, hl, hh;
      ll = vm8(a[7:0], b[7:0]);
      lh = vm8(a[7:0], b[15:8]);
      hl = vm8(a[15:8], b[7:0]);
      hh = vm8(a[15:8], b[15:8]);
      return {16'b0, ll} + {8'b0, lh, 8'b0}
           + {8'b0, hl, 8'b0} + {hh, 16'b0};
   endfunction

   logic [OP_W-1:0]   w_ma;
   logic [OP_W-1:0]   w_mb;
   logic [PROD_W-1:0] w_u;
   logic              w_neg;

   // 16-bit magnitude of -32768 is 0x8000, still exact unsigned.
   assign w_ma  = i_a[OP_W-1] ? (~i_a + 1'b1) : i_a;
   assign w_mb  = i_b[OP_W-1] ? (~i_b + 1'b1) : i_b;
   assign w_neg = i_a[OP_W-1] ^ i_b[OP_W-1];
   assign w_u   = vm16(w_ma, w_mb);
   assign o_p   = w_neg ? (~w_u + 1'b1) : w_u;

endmodule

// File: rtl/vedic_mac.sv
// vedic_mac: P1 operand regs, vedic1, P2 product reg, frame
// accumulator and a valid/ready result register.
module vedic_mac
   import vedic_mac_pkg::*;
#(
   parameter int ACC_W = ACC_W_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [OP_W-1:0]         in_a,
   input  logic [OP_W-1:0]         in_b,
   input  logic                    in_last,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic signed [ACC_W-1:0] out_acc,
   output logic [CNT_W-1:0]        out_count,
   output logic                    out_ovf
);

   state_t r_state;
   state_t w_state_nxt;

   logic [OP_W-1:0]          r_a;
   logic [OP_W-1:0]          r_b;
   logic                     r_last1;
   logic                     r_v1;

   logic [PROD_W-1:0]        w_prod;
   logic signed [PROD_W-1:0] r_prod;
   logic                     r_last2;
   logic                     r_v2;

   logic signed [ACC_W-1:0]  r_acc;
   logic [CNT_W-1:0]         r_cnt;
   logic                     r_ovf;

   logic                     r_out_valid;
   logic signed [ACC_W-1:0]  r_out_acc;
   logic [CNT_W-1:0]         r_out_cnt;
   logic                     r_out_ovf;

   logic                     w_in_fire;
   logic                     w_out_fire;
   logic                     w_close;
   logic signed [ACC_W-1:0]  w_prod_ext;
   logic signed [ACC_W-1:0]  w_sum;
   logic                     w_ovf_now;
   logic [CNT_W-1:0]         w_cnt_inc;

   // in_ready decodes the state register only.
   assign in_ready   = (r_state == RUN);
   assign w_in_fire  = in_valid & in_ready;
   assign w_out_fire = r_out_valid & out_ready;
   assign w_close    = r_v2 & r_last2;

   assign out_valid  = r_out_valid;
   assign out_acc    = r_out_acc;
   assign out_count  = r_out_cnt;
   assign out_ovf    = r_out_ovf;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_a     <= '0;
         r_b     <= '0;
         r_last1 <= 1'b0;
         r_v1    <= 1'b0;
      end else begin
         r_v1 <= w_in_fire;
         if (w_in_fire) begin
            r_a     <= in_a;
            r_b     <= in_b;
            r_last1 <= in_last;
         end
      end
   end

   vedic1 u_vedic1 (
      .i_a (r_a),
      .i_b (r_b),
      .o_p (w_prod)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_prod  <= '0;
         r_last2 <= 1'b0;
         r_v2    <= 1'b0;
      end else begin
         r_v2 <= r_v1;
         if (r_v1) begin
            r_prod  <= w_prod;
            r_last2 <= r_last1;
         end
      end
   end

   assign w_prod_ext = ACC_W'(r_prod);
   assign w_sum      = r_acc + w_prod_ext;
   assign w_ovf_now  = add_ovf(r_acc[ACC_W-1],
                               w_prod_ext[ACC_W-1],
                               w_sum[ACC_W-1]);
   assign w_cnt_inc  = (&r_cnt) ? r_cnt : r_cnt + 1'b1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_acc <= '0;
         r_cnt <= '0;
         r_ovf <= 1'b0;
      end else if (r_v2) begin
         if (r_last2) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
         end else begin
            r_acc <= w_sum;
            r_cnt <= w_cnt_inc;
            r_ovf <= r_ovf | w_ovf_now;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_out_acc   <= '0;
         r_out_cnt   <= '0;
         r_out_ovf   <= 1'b0;
      end else if (w_close) begin
         r_out_valid <= 1'b1;
         r_out_acc   <= w_sum;
         r_out_cnt   <= w_cnt_inc;
         r_out_ovf   <= r_ovf | w_ovf_now;
      end else if (w_out_fire) begin
         r_out_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= RUN;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         RUN: begin
            if (w_in_fire && in_last) begin
               w_state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            if (w_close) begin
               w_state_nxt = HOLD;
            end
         end
         HOLD: begin
            if (w_out_fire) begin
               w_state_nxt = RUN;
            end
         end
         default: w_state_nxt = RUN;
      endcase
   end

endmodule

// File: tb/tb_vedic_mac.sv
// Directed bench for vedic_mac: ACC_W=40 and ACC_W=32 instances in
// lockstep against a range-checking reference model and scoreboard.
module tb_vedic_mac;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic               rst;
   logic               in_valid;
   logic               in_last;
   logic               out_ready;
   logic signed [15:0] in_a;
   logic signed [15:0] in_b;

   logic               in_ready;
   logic               out_valid;
   logic signed [39:0] out_acc;
   logic [15:0]        out_count;
   logic               out_ovf;

   logic               in_ready32;
   logic               out_valid32;
   logic signed [31:0] out_acc32;
   logic [15:0]        out_count32;
   logic               out_ovf32;

   vedic_mac u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_acc   (out_acc),
      .out_count (out_count),
      .out_ovf   (out_ovf)
   );

   vedic_mac #(.ACC_W(32), .CNT_W(16)) u_dut32 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready32),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_last   (in_last),
      .out_valid (out_valid32),
      .out_ready (out_ready),
      .out_acc   (out_acc32),
      .out_count (out_count32),
      .out_ovf   (out_ovf32)
   );

   typedef struct {
      longint      acc40;
      longint      acc32;
      logic [15:0] cnt;
      logic        ovf40;
      logic        ovf32;
   } exp_t;

   exp_t sb[$];

   int n_vec = 0;
   int n_err = 0;

   longint m40 = 0;
   longint m32 = 0;
   int     mcnt = 0;
   bit     mo40 = 1'b0;
   bit     mo32 = 1'b0;

   localparam longint MAX40 = 64'sd549755813887;
   localparam longint MIN40 = -64'sd549755813888;
   localparam longint MAX32 = 64'sd2147483647;
   localparam longint MIN32 = -64'sd2147483648;

   task automatic chk(input string tag,
                      input logic signed [63:0] obs,
                      input logic signed [63:0] expv);
      n_vec++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   task automatic fail_now(input string tag);
      n_vec++;
      n_err++;
      $error("FAIL %s: event did not occur", tag);
   endtask

   task automatic model_add(input longint p);
      longint t;
      logic signed [39:0] w40;
      logic signed [31:0] w32;
      t = m40 + p;
      if (t > MAX40 || t < MIN40) mo40 = 1'b1;
      w40 = t[39:0];
      m40 = longint'(w40);
      t = m32 + p;
      if (t > MAX32 || t < MIN32) mo32 = 1'b1;
      w32 = t[31:0];
      m32 = longint'(w32);
      if (mcnt < 65535) mcnt++;
   endtask

   task automatic model_close();
      exp_t e;
      e.acc40 = m40;
      e.acc32 = m32;
      e.cnt   = 16'(mcnt);
      e.ovf40 = mo40;
      e.ovf32 = mo32;
      sb.push_back(e);
      m40 = 0;
      m32 = 0;
      mcnt = 0;
      mo40 = 1'b0;
      mo32 = 1'b0;
   endtask

   // Entered and left at posedge+1.
   task automatic send_beat(input logic signed [15:0] a,
                            input logic signed [15:0] b,
                            input logic last,
                            input bit use_model);
      int budget;
      bit rdy;
      in_a = a;
      in_b = b;
      in_last = last;
      in_valid = 1'b1;
      rdy = 1'b0;
      budget = 0;
      while (!rdy && budget < 50) begin
         @(negedge clk);
         rdy = in_ready;
         @(posedge clk);
         #1;
         budget++;
      end
      in_valid = 1'b0;
      in_last = 1'b0;
      if (!rdy) fail_now("accept_timeout");
      if (use_model) begin
         model_add(longint'(a) * longint'(b));
         if (last) model_close();
      end
   endtask

   task automatic wait_result(output int lat, output logic rdy_first);
      lat = 0;
      rdy_first = 1'b1;
      while (!out_valid && lat < 20) begin
         @(negedge clk);
         lat++;
         if (lat == 1) rdy_first = in_ready;
      end
      if (!out_valid) fail_now("result_timeout");
   endtask

   // Called at a negedge with out_valid high; leaves at posedge+1.
   task automatic check_result(input string tag);
      exp_t e;
      if (sb.size() == 0) begin
         fail_now({tag, "_sb_empty"});
      end else begin
         e = sb.pop_front();
         chk({tag, "_valid32"}, 64'(out_valid32), 64'd1);
         chk({tag, "_acc40"}, out_acc, e.acc40);
         chk({tag, "_acc32"}, out_acc32, e.acc32);
         chk({tag, "_cnt"}, 64'(out_count), 64'(e.cnt));
         chk({tag, "_cnt32"}, 64'(out_count32), 64'(e.cnt));
         chk({tag, "_ovf40"}, 64'(out_ovf), 64'(e.ovf40));
         chk({tag, "_ovf32"}, 64'(out_ovf32), 64'(e.ovf32));
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      int lat;
      logic rdy_first;
      logic signed [39:0] s_acc;
      logic [15:0] s_cnt;
      logic s_ovf;
      bit stable;
      bit ghost;
      int gap;
      logic signed [15:0] ra;
      logic signed [15:0] rb;

      rst = 1'b1;
      in_valid = 1'b0;
      in_last = 1'b0;
      in_a = '0;
      in_b = '0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_acc", out_acc, 64'sd0);
      chk("rst_out_count", 64'(out_count), 64'd0);
      chk("rst_out_ovf", 64'(out_ovf), 64'd0);
      @(posedge clk);
      #1;

      send_beat(16'sd3, 16'sd4, 1'b0, 1'b1);
      send_beat(-16'sd5, 16'sd6, 1'b0, 1'b1);
      send_beat(16'sd7, -16'sd8, 1'b0, 1'b1);
      send_beat(-16'sd2, -16'sd9, 1'b1, 1'b1);
      wait_result(lat, rdy_first);
      chk("a_latency", 64'(lat), 64'd3);
      chk("a_drain_rdy", 64'(rdy_first), 64'd0);
      check_result("a");
      @(negedge clk);
      chk("a_rdy_after_xfer", 64'(in_ready), 64'd1);
      chk("a_valid_cleared", 64'(out_valid), 64'd0);
      @(posedge clk);
      #1;

      send_beat(-16'sd32768, -16'sd32768, 1'b1, 1'b1);
      wait_result(lat, rdy_first);
      chk("neg_max_acc", out_acc, 64'sd1073741824);
      check_result("neg_max");

      send_beat(16'sd32767, 16'sd32767, 1'b0, 1'b1);
      send_beat(16'sd32767, 16'sd32767, 1'b0, 1'b1);
      send_beat(16'sd32767, 16'sd32767, 1'b1, 1'b1);
      wait_result(lat, rdy_first);
      chk("wrap_ovf32", 64'(out_ovf32), 64'd1);
      check_result("wrap");

      send_beat(16'sd1, 16'sd1, 1'b1, 1'b1);
      wait_result(lat, rdy_first);
      check_result("after_ovf");

      out_ready = 1'b0;
      send_beat(16'sd100, -16'sd3, 1'b0, 1'b1);
      send_beat(16'sd5, 16'sd5, 1'b1, 1'b1);
      wait_result(lat, rdy_first);
      s_acc = out_acc;
      s_cnt = out_count;
      s_ovf = out_ovf;
      stable = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (!out_valid || out_acc !== s_acc || out_count !== s_cnt ||
             out_ovf !== s_ovf || in_ready || in_ready32)
            stable = 1'b0;
      end
      chk("hold_stable", 64'(stable), 64'd1);
      check_result("hold");
      out_ready = 1'b1;
      @(negedge clk);
      chk("hold_rdy_before_xfer", 64'(in_ready), 64'd0);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("hold_rdy_after_xfer", 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;

      for (int i = 0; i < 20; i++) begin
         gap = $urandom_range(0, 3);
         repeat (gap) begin
            @(posedge clk);
            #1;
         end
         ra = 16'($urandom);
         rb = 16'($urandom);
         send_beat(ra, rb, (i == 19), 1'b1);
      end
      wait_result(lat, rdy_first);
      check_result("rand20");

      send_beat(16'sd10, 16'sd10, 1'b0, 1'b0);
      send_beat(-16'sd7, 16'sd9, 1'b1, 1'b0);
      @(negedge clk);
      chk("rst_drain_rdy", 64'(in_ready), 64'd0);
      rst = 1'b1;
      #1;
      chk("arst_out_valid", 64'(out_valid), 64'd0);
      chk("arst_out_acc", out_acc, 64'sd0);
      chk("arst_out_count", 64'(out_count), 64'd0);
      chk("arst_out_ovf", 64'(out_ovf), 64'd0);
      chk("arst_in_ready", 64'(in_ready), 64'd1);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      ghost = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (out_valid) ghost = 1'b1;
      end
      chk("no_ghost_result", 64'(ghost), 64'd0);
      @(posedge clk);
      #1;
      send_beat(16'sd2, 16'sd3, 1'b1, 1'b1);
      wait_result(lat, rdy_first);
      chk("post_rst_acc", out_acc, 64'sd6);
      check_result("post_rst");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

endmodule
